// File: rtl/multicycle_control_unit_if.sv
// Bus bundle between the multicycle control unit and the IR, datapath and data-memory side.
interface multicycle_control_unit_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                instr_valid;
  logic                mem_ready;
  logic                cmp_flag;
  logic                ir_wr;
  logic                pc_wr;
  logic [ALU_OP_W-1:0] alu_op;
  logic                reg_wr;
  logic                reg_dst;
  logic                alu_src;
  logic                jump;
  logic                cmp;
  logic                mem_rd;
  logic                mem_wr;
  logic                mem_to_reg;
  logic                busy;
  logic                halted;
  logic                illegal;
  logic [CNT_W-1:0]    retired;

  modport slave (
    input  opcode, instr_valid, mem_ready, cmp_flag,
    output ir_wr, pc_wr, alu_op, reg_wr, reg_dst, alu_src, jump, cmp,
           mem_rd, mem_wr, mem_to_reg, busy, halted, illegal, retired
  );

  modport master (
    output opcode, instr_valid, mem_ready, cmp_flag,
    input  ir_wr, pc_wr, alu_op, reg_wr, reg_dst, alu_src, jump, cmp,
           mem_rd, mem_wr, mem_to_reg, busy, halted, illegal, retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC core with memory waits, halt and retire count.
// Define CU_ILLEGAL_TRAP_EN to trap illegal opcodes in a TRAP state instead of executing them as NOP.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_control_unit_if.slave bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
`ifdef CU_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP   = 3'd6;
`endif

  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_NOP  = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd14;
  localparam logic [3:0] OP_ILL  = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef struct packed {
    logic                pc_wr;
    logic [ALU_OP_W-1:0] alu_op;
    logic                reg_wr;
    logic                reg_dst;
    logic                alu_src;
    logic                jump;
    logic                cmp;
    logic                mem_rd;
    logic                mem_wr;
    logic                mem_to_reg;
    logic                busy;
    logic                halted;
    logic                illegal;
  } ctrl_t;

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                taken_q, taken_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [3:0]          code_q, code_d;

  function automatic logic is_illegal(input logic [OPCODE_W-1:0] op);
    return ((op >> 4) != '0) || (op[3:0] == OP_ILL);
  endfunction

  // Illegal codes collapse onto NOP so they can never alias a real operation.
  function automatic logic [3:0] code_of(input logic [OPCODE_W-1:0] op);
    return is_illegal(op) ? OP_NOP : op[3:0];
  endfunction

  function automatic logic [ALU_OP_W-1:0] alu_of(input logic [3:0] code);
    if (code <= 4'd6)                      return ALU_OP_W'(code[2:0]);
    if (code == OP_CMP || code == OP_BEQ) return ALU_OP_W'(ALU_SUB);
    return ALU_OP_W'(ALU_ADD);
  endfunction

  assign code_q = code_of(op_q);
  assign code_d = code_of(op_d);

  // Next-state, opcode latch, branch-flag sample and retire count.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    taken_d   = taken_q;
    retired_d = retired_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.instr_valid) begin
          op_d    = bus.opcode;
          taken_d = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (code_q == OP_HALT) state_d = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
        else if (is_illegal(op_q)) state_d = S_TRAP;
`endif
        else state_d = S_EXEC;
      end
      S_EXEC: begin
        if (code_q == OP_BEQ) taken_d = bus.cmp_flag;
        state_d = (code_q == OP_LW || code_q == OP_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.mem_ready) state_d = S_WB;
      end
      S_WB: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      default: ;
    endcase
  end

  // Strobes are decoded from the next state so they come straight out of flops.
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      S_DECODE: ctrl_d.busy = 1'b1;
      S_EXEC: begin
        ctrl_d.busy    = 1'b1;
        ctrl_d.alu_op  = alu_of(code_d);
        ctrl_d.alu_src = (code_d == OP_ADDI);
        ctrl_d.reg_dst = (code_d <= 4'd6);
        ctrl_d.cmp     = (code_d == OP_CMP);
      end
      S_MEM: begin
        ctrl_d.busy       = 1'b1;
        ctrl_d.alu_op     = alu_of(code_d);
        ctrl_d.mem_rd     = (code_d == OP_LW);
        ctrl_d.mem_wr     = (code_d == OP_SW);
        ctrl_d.mem_to_reg = (code_d == OP_LW);
      end
      S_WB: begin
        ctrl_d.busy       = 1'b1;
        ctrl_d.alu_op     = alu_of(code_d);
        ctrl_d.pc_wr      = 1'b1;
        ctrl_d.reg_wr     = (code_d <= OP_LW);
        ctrl_d.reg_dst    = (code_d <= 4'd6);
        ctrl_d.mem_to_reg = (code_d == OP_LW);
        ctrl_d.jump       = (code_d == OP_JMP) || ((code_d == OP_BEQ) && taken_d);
      end
      S_HALT: ctrl_d.halted = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctrl_d.busy    = 1'b1;
        ctrl_d.illegal = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      taken_q   <= 1'b0;
      retired_q <= '0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      taken_q   <= taken_d;
      retired_q <= retired_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // ir_wr is the one strobe that follows an input within the cycle.
  assign bus.ir_wr      = rst_n && (state_q == S_FETCH) && bus.instr_valid;
  assign bus.pc_wr      = ctrl_q.pc_wr;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.reg_wr     = ctrl_q.reg_wr;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.alu_src    = ctrl_q.alu_src;
  assign bus.jump       = ctrl_q.jump;
  assign bus.cmp        = ctrl_q.cmp;
  assign bus.mem_rd     = ctrl_q.mem_rd;
  assign bus.mem_wr     = ctrl_q.mem_wr;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.busy       = ctrl_q.busy;
  assign bus.halted     = ctrl_q.halted;
  assign bus.illegal    = ctrl_q.illegal;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-feature tasks plus a write-back scoreboard.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(4), .ALU_OP_W(3), .CNT_W(16)) bus ();
  multicycle_control_unit_if #(.OPCODE_W(4), .ALU_OP_W(3), .CNT_W(2))  bus2 ();

  multicycle_control_unit #(.OPCODE_W(4), .ALU_OP_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  multicycle_control_unit #(.OPCODE_W(4), .ALU_OP_W(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct packed {
    logic [3:0] op;
    logic       reg_wr;
    logic       jump;
    logic       mem_to_reg;
  } wb_exp_t;

  wb_exp_t     sb_q[$];
  wb_exp_t     mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_retired;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected write-back strobes from the opcode map (15 runs as NOP when not trapped).
  task automatic push_exp(input logic [3:0] op, input logic taken);
    wb_exp_t e;
    e.op         = op;
    e.reg_wr     = (op <= 4'd8);
    e.jump       = (op == 4'd12) || ((op == 4'd11) && taken);
    e.mem_to_reg = (op == 4'd8);
    sb_q.push_back(e);
  endtask

  function automatic logic [2:0] exp_alu(input logic [3:0] op);
    if (op <= 4'd6) return op[2:0];
    if (op == 4'd10 || op == 4'd11) return 3'b001;
    return 3'b000;
  endfunction

  task automatic exec_instr(input logic [3:0] op, input int nwait, input logic cf_exec, input logic cf_wb);
    push_exp(op, cf_exec);
    bus.opcode = op; bus.instr_valid = 1'b1; step();
    bus.instr_valid = 1'b0; bus.opcode = 4'($urandom); step();
    bus.cmp_flag = cf_exec;
    if (op == 4'd8 || op == 4'd9) begin
      step();
      for (int i = 0; i < nwait; i++) begin bus.mem_ready = 1'b0; step(); end
      bus.mem_ready = 1'b1; step();
    end else begin
      step();
    end
    bus.cmp_flag = cf_wb; step();
    bus.cmp_flag = 1'b0;
    exp_retired = exp_retired + 16'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_retired = 16'd0;
    step();
  endtask

  // Scoreboard: every write-back cycle pops one expected instruction.
  always @(negedge clk) begin
    if (rst_n && bus.pc_wr) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_wb: pc_wr=1 got, no instruction expected");
      end else begin
        mon_e = sb_q.pop_front();
        if ({bus.reg_wr, bus.jump, bus.mem_to_reg} !== {mon_e.reg_wr, mon_e.jump, mon_e.mem_to_reg}) begin
          n_fail++;
          $display("FAIL sb_wb op=%0d: {reg_wr,jump,mem_to_reg} got %b%b%b expected %b%b%b", mon_e.op,
                   bus.reg_wr, bus.jump, bus.mem_to_reg, mon_e.reg_wr, mon_e.jump, mon_e.mem_to_reg);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; bus.instr_valid = 1'b1; bus.opcode = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.ir_wr, bus.pc_wr, bus.reg_wr, bus.mem_rd, bus.mem_wr, bus.jump, bus.alu_op, bus.busy, bus.halted, bus.illegal} !== '0) begin
      n_fail++; $display("FAIL reset_strobes: got ir_wr=%b pc_wr=%b reg_wr=%b busy=%b expected all 0",
                         bus.ir_wr, bus.pc_wr, bus.reg_wr, bus.busy);
    end
    n_checks++;
    if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", bus.retired); end
    rst_n = 1'b1; #1;
    n_checks++;
    if (bus.ir_wr !== 1'b1) begin n_fail++; $display("FAIL reset_release_ir_wr: got %b expected 1", bus.ir_wr); end
    bus.instr_valid = 1'b0; #1;
    n_checks++;
    if (bus.ir_wr !== 1'b0) begin n_fail++; $display("FAIL ir_wr_follows_valid: got %b expected 0", bus.ir_wr); end
    step();
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL no_accept_without_valid: busy got %b expected 0", bus.busy); end
    exp_retired = 16'd0;
  endtask

  task automatic test_alu();
    logic [3:0] op;
    for (int i = 0; i < 10; i++) begin
      op = (i < 8) ? 4'(i) : ((i == 8) ? 4'd10 : 4'd13);
      push_exp(op, 1'b0);
      bus.opcode = op; bus.instr_valid = 1'b1; #1;
      n_checks++;
      if (bus.ir_wr !== 1'b1) begin n_fail++; $display("FAIL alu_ir_wr op=%0d: got %b expected 1", op, bus.ir_wr); end
      step();
      bus.instr_valid = 1'b0; bus.opcode = 4'($urandom);
      n_checks++;
      if ({bus.busy, bus.pc_wr, bus.reg_wr, bus.alu_op, bus.cmp, bus.mem_rd, bus.mem_wr} !== 9'b1_0000_0000) begin
        n_fail++; $display("FAIL decode_quiet op=%0d: busy=%b pc_wr=%b reg_wr=%b alu_op=%b expected busy only",
                           op, bus.busy, bus.pc_wr, bus.reg_wr, bus.alu_op);
      end
      step();
      if (op != 4'd13) begin
        n_checks++;
        if (bus.alu_op !== exp_alu(op)) begin
          n_fail++; $display("FAIL exec_alu_op op=%0d: got %b expected %b", op, bus.alu_op, exp_alu(op));
        end
      end
      n_checks++;
      if ({bus.reg_dst, bus.alu_src, bus.cmp, bus.reg_wr} !== {op <= 4'd6, op == 4'd7, op == 4'd10, 1'b0}) begin
        n_fail++; $display("FAIL exec_ctrl op=%0d: {reg_dst,alu_src,cmp,reg_wr} got %b%b%b%b", op,
                           bus.reg_dst, bus.alu_src, bus.cmp, bus.reg_wr);
      end
      step();
      n_checks++;
      if (bus.pc_wr !== 1'b1) begin n_fail++; $display("FAIL wb_pc_wr op=%0d: got %b expected 1", op, bus.pc_wr); end
      step();
      exp_retired = exp_retired + 16'd1;
      n_checks++;
      if (bus.retired !== exp_retired) begin
        n_fail++; $display("FAIL alu_retired op=%0d: got %0d expected %0d", op, bus.retired, exp_retired);
      end
    end
  endtask

  task automatic test_mem(input logic [3:0] op, input int nwait);
    int rd_cnt, wr_cnt, rw_cnt, wb_at;
    rd_cnt = 0; wr_cnt = 0; rw_cnt = 0; wb_at = -1;
    push_exp(op, 1'b0);
    bus.opcode = op;
    for (int c = 0; c < 24 && wb_at < 0; c++) begin
      bus.instr_valid = (c == 0);
      bus.mem_ready   = (c < 3) || (c >= 3 + nwait);
      if (bus.mem_rd) rd_cnt++;
      if (bus.mem_wr) wr_cnt++;
      if (bus.reg_wr) rw_cnt++;
      if ((bus.mem_rd || bus.mem_wr) && bus.mem_to_reg !== (op == 4'd8)) begin
        n_checks++; n_fail++;
        $display("FAIL mem_to_reg_in_mem op=%0d: got %b", op, bus.mem_to_reg);
      end
      if (bus.pc_wr) wb_at = c;
      step();
    end
    bus.mem_ready = 1'b1;
    n_checks++;
    if (wb_at !== 4 + nwait) begin n_fail++; $display("FAIL mem_wb_cycle op=%0d: got %0d expected %0d", op, wb_at, 4 + nwait); end
    n_checks++;
    if (rd_cnt !== ((op == 4'd8) ? nwait + 1 : 0)) begin n_fail++; $display("FAIL mem_rd_cycles op=%0d: got %0d", op, rd_cnt); end
    n_checks++;
    if (wr_cnt !== ((op == 4'd9) ? nwait + 1 : 0)) begin n_fail++; $display("FAIL mem_wr_cycles op=%0d: got %0d", op, wr_cnt); end
    n_checks++;
    if (rw_cnt !== ((op == 4'd8) ? 1 : 0)) begin n_fail++; $display("FAIL mem_reg_wr_cycles op=%0d: got %0d", op, rw_cnt); end
    exp_retired = exp_retired + 16'd1;
    n_checks++;
    if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL mem_retired: got %0d expected %0d", bus.retired, exp_retired); end
  endtask

  task automatic test_reset_mid();
    bus.opcode = 4'd8; bus.instr_valid = 1'b1; step();
    bus.instr_valid = 1'b0; bus.mem_ready = 1'b0;
    repeat (3) step();
    n_checks++;
    if (bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL mid_precondition mem_rd: got %b expected 1", bus.mem_rd); end
    rst_n = 1'b0; #1;
    n_checks++;
    if ({bus.pc_wr, bus.reg_wr, bus.mem_rd, bus.busy, bus.retired} !== '0) begin
      n_fail++; $display("FAIL mid_reset: pc_wr=%b reg_wr=%b mem_rd=%b busy=%b retired=%0d expected 0",
                         bus.pc_wr, bus.reg_wr, bus.mem_rd, bus.busy, bus.retired);
    end
    bus.mem_ready = 1'b1; step();
    rst_n = 1'b1; exp_retired = 16'd0; step();
    n_checks++;
    if ({bus.busy, bus.pc_wr} !== 2'b00) begin n_fail++; $display("FAIL mid_after_release: busy=%b pc_wr=%b", bus.busy, bus.pc_wr); end
  endtask

  task automatic test_branch();
    exec_instr(4'd11, 0, 1'b1, 1'b1);
    exec_instr(4'd11, 0, 1'b0, 1'b1);
    exec_instr(4'd11, 0, 1'b1, 1'b0);
    exec_instr(4'd12, 0, 1'b0, 1'b0);
    exec_instr(4'd12, 0, 1'b1, 1'b1);
    n_checks++;
    if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL branch_retired: got %0d expected %0d", bus.retired, exp_retired); end
  endtask

  task automatic test_back_to_back();
    int ir_cnt;
    ir_cnt = 0;
    for (int k = 0; k < 3; k++) push_exp(4'd13, 1'b0);
    bus.opcode = 4'd13; bus.instr_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.ir_wr) ir_cnt++;
      step();
    end
    bus.instr_valid = 1'b0;
    exp_retired = exp_retired + 16'd3;
    n_checks++;
    if (ir_cnt !== 3) begin n_fail++; $display("FAIL b2b_issue_rate: ir_wr cycles got %0d expected 3", ir_cnt); end
    n_checks++;
    if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL b2b_retired: got %0d expected %0d", bus.retired, exp_retired); end
  endtask

  task automatic test_halt();
    bus.opcode = 4'd14; bus.instr_valid = 1'b1; step();
    step();
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if ({bus.halted, bus.pc_wr, bus.busy, bus.ir_wr, bus.reg_wr} !== 5'b10000) begin
        n_fail++; $display("FAIL halt_hold c=%0d: halted=%b pc_wr=%b busy=%b ir_wr=%b", c,
                           bus.halted, bus.pc_wr, bus.busy, bus.ir_wr);
      end
      step();
    end
    n_checks++;
    if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL halt_retired: got %0d expected %0d", bus.retired, exp_retired); end
    bus.instr_valid = 1'b0;
    do_reset();
    n_checks++;
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_cleared: got %b expected 0", bus.halted); end
  endtask

  task automatic test_illegal();
`ifdef CU_ILLEGAL_TRAP_EN
    logic [15:0] before;
    before = exp_retired;
    bus.opcode = 4'd15; bus.instr_valid = 1'b1; step();
    bus.instr_valid = 1'b0; step();
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if ({bus.illegal, bus.pc_wr, bus.reg_wr, bus.mem_rd, bus.mem_wr, bus.jump, bus.halted} !== 7'b1000000) begin
        n_fail++; $display("FAIL trap_hold c=%0d: illegal=%b pc_wr=%b reg_wr=%b", c, bus.illegal, bus.pc_wr, bus.reg_wr);
      end
      step();
    end
    n_checks++;
    if (bus.retired !== before) begin n_fail++; $display("FAIL trap_retired: got %0d expected %0d", bus.retired, before); end
    do_reset();
    n_checks++;
    if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL trap_cleared: got %b expected 0", bus.illegal); end
`else
    exec_instr(4'd15, 0, 1'b1, 1'b1);
    n_checks++;
    if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_tied: got %b expected 0", bus.illegal); end
    n_checks++;
    if (bus.retired !== exp_retired) begin n_fail++; $display("FAIL illegal_nop_retired: got %0d expected %0d", bus.retired, exp_retired); end
`endif
  endtask

  task automatic test_wrap();
    logic [1:0] exp2;
    n_checks++;
    if (bus2.retired !== 2'd0) begin n_fail++; $display("FAIL wrap_start: got %0d expected 0", bus2.retired); end
    bus2.opcode = 4'd13; bus2.instr_valid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 17) bus2.instr_valid = 1'b0;
      if (c % 4 == 0) begin
        exp2 = 2'((c / 4) % 4);
        n_checks++;
        if (bus2.retired !== exp2) begin n_fail++; $display("FAIL wrap_retired c=%0d: got %0d expected %0d", c, bus2.retired, exp2); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.opcode = 4'd0; bus.instr_valid = 1'b0; bus.mem_ready = 1'b1; bus.cmp_flag = 1'b0;
    bus2.opcode = 4'd13; bus2.instr_valid = 1'b0; bus2.mem_ready = 1'b1; bus2.cmp_flag = 1'b0;
    exp_retired = 16'd0;
    test_reset();
    test_alu();
    test_mem(4'd8, 3);
    test_mem(4'd9, 2);
    test_mem(4'd8, 0);
    test_reset_mid();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_halt();
    test_wrap();
    repeat (2) step();
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d expected write-backs never seen", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- Multi-cycle, parametrised successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states and emits per-state datapath strobes for the 16-bit RISC core.
- Adds memory-wait handshaking, a halt state, branch-flag sampling, a retired-instruction counter and optional illegal-opcode trapping.
- Sits between instruction memory/IR and the register file, ALU and data-memory port.

## Interface
- OPCODE_W, default 4: opcode width; only codes 0..15 are legal, any nonzero bit above bit 3 is illegal.
- ALU_OP_W, default 3: alu_op width, minimum 3.
- CNT_W, default 16: retired-instruction counter width.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  OPCODE_W  instruction opcode; sampled only in FETCH when instr_valid=1.
- instr_valid  input  1  instruction memory has a valid word.
- mem_ready  input  1  data memory finished the current access.
- cmp_flag  input  1  equal flag from the datapath flag register.
- ir_wr, pc_wr  output  1  IR load strobe and PC update strobe.
- alu_op  output  ALU_OP_W  ALU operation code.
- reg_wr, reg_dst, alu_src, jump, cmp, mem_rd, mem_wr, mem_to_reg  output  1  datapath controls.
- busy  output  1  high in every state except FETCH and HALT.
- halted  output  1  high in HALT.
- illegal  output  1  high in TRAP.
- retired  output  CNT_W  count of completed instructions.

## Operation
**Opcode map.** alu_op codes: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLL=101, SRL=110, PASS=111.
- 0–6: R-type ADD, SUB, AND, OR, XOR, SLL, SRL; reg_dst=1.
- 7: ADDI; alu_src=1.
- 8: LW. 9: SW. 10: CMP (SUB with cmp=1, no register write). 11: BEQ. 12: JMP. 13: NOP. 14: HALT.
- 15 and out-of-range codes: illegal.

**FETCH.**
- Waits for instr_valid. When it is high, asserts ir_wr for that cycle, latches opcode into an internal register, and moves to DECODE.

**DECODE.**
- One cycle, no strobes. Moves to HALT for opcode 14, to TRAP for illegal opcodes when trapping is compiled in, otherwise to EXEC.

**EXEC.** Drives alu_op and alu_src, and drives cmp for CMP.
- BEQ samples cmp_flag into a taken register.
- LW and SW go to MEM; everything else goes to WB.

**MEM.**
- Holds mem_rd (LW) or mem_wr (SW) steady while mem_ready=0, and moves to WB on the cycle mem_ready=1.
- LW also asserts mem_to_reg in MEM and WB.

**WB.**
- Always asserts pc_wr.
- reg_wr=1 for opcodes 0–9 except 9 (SW).
- jump=1 for JMP, and for BEQ when taken=1.
- retired increments by 1 and wraps modulo 2^CNT_W. Next state is FETCH.

**HALT.** Holds until reset; all strobes 0.

**Outputs.**
- All outputs are Moore: a function of state, latched opcode and taken only. No input reaches an output combinationally, except ir_wr = FETCH && instr_valid.
- Outputs not listed for a state are 0. alu_op is 000 outside EXEC/MEM/WB.

## Timing
- **Reset:** on rst_n=0 the block enters FETCH immediately, asynchronously. All strobes are 0, retired=0, taken=0, and the latched opcode is 0.
- **Reset mid-operation:** abandons the instruction with no reg_wr and no pc_wr.
- **Latency from the instr_valid cycle:**
  - ALU, CMP, BEQ, JMP, NOP: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW/SW: 5 cycles plus the number of mem_ready=0 cycles in MEM.
- **Back-to-back issue:** the next FETCH is the cycle after WB, so a new instruction is accepted at most every 4 cycles.
- **Bus holds:** mem_rd/mem_wr stay asserted continuously across wait cycles. mem_ready is ignored outside MEM.
- **Branch flag:** cmp_flag changing after EXEC does not affect a BEQ already in flight.
- **Counter wrap:** retired at 2^CNT_W−1 wraps to 0 on the next WB.

## Configuration
- **With `CU_ILLEGAL_TRAP_EN` defined:** an illegal opcode goes DECODE→TRAP.
  - TRAP asserts illegal=1 with all strobes 0 and is left only by reset.
  - retired does not increment.
- **Without the macro:** illegal opcodes execute as NOP (EXEC→WB with pc_wr=1 only, retired increments).
  - The TRAP state is absent and illegal is tied to 0.

## Test plan
- **Reset:** reset with instr_valid=1 → all strobes 0 and retired=0. After release, ir_wr=1 in the first cycle.
- **ADD (0000):** DECODE 1 cycle later. EXEC shows alu_op=000 and reg_dst=1. WB shows reg_wr=1 and pc_wr=1. retired=1 after 4 cycles.
- **LW with 3 wait cycles:** mem_rd held for 4 cycles, then WB with reg_wr=1 and mem_to_reg=1. Total 8 cycles.
- **SW:** mem_wr=1 held until mem_ready, and reg_wr stays 0 throughout.
- **BEQ:**
  - With cmp_flag=1 in EXEC: WB shows jump=1.
  - With cmp_flag=0 in EXEC then 1 in WB: jump=0.
  - JMP: always jump=1.
- **Halt, illegal and wrap:**
  - HALT (1110): halted=1 persists 20 cycles with no pc_wr.
  - Opcode 1111 with `CU_ILLEGAL_TRAP_EN`: illegal=1 until reset. Without the macro: behaves as NOP.
  - With CNT_W=2, five NOPs give retired=1.
